// File: rtl/rvfi_trace_serializer.sv
// rvfi_trace_serializer: compacts up to NrPorts retired-instruction records per cycle into a
// circular FIFO, tags each with a retirement sequence number and drains them one per handshake.
`default_nettype none

module rvfi_trace_serializer #(
    parameter  int NrPorts  = 2,
    parameter  int RecWidth = 256,
    parameter  int Depth    = 16,
    parameter  int SeqWidth = 16,
    parameter  int CntWidth = 16,
    localparam int PortW    = (NrPorts > 1) ? $clog2(NrPorts) : 1,
    localparam int LvlW     = $clog2(Depth) + 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrPorts-1:0]                rec_valid_i,
    input  logic [NrPorts-1:0][RecWidth-1:0]  rec_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [RecWidth-1:0]               out_rec_o,
    output logic [PortW-1:0]                  out_port_o,
    output logic [SeqWidth-1:0]               out_seq_o,
    output logic [LvlW-1:0]                   level_o,
    output logic                              overflow_o,
    output logic [CntWidth-1:0]               drop_cnt_o,
    input  logic                              clear_i
);

    localparam int AddrW = $clog2(Depth);
    localparam int CalcW = LvlW + 1;

    logic [RecWidth-1:0] mem_rec  [Depth];
    logic [PortW-1:0]    mem_port [Depth];
    logic [SeqWidth-1:0] mem_seq  [Depth];

    logic [AddrW-1:0]    rptr;
    logic [AddrW-1:0]    wptr;
    logic [LvlW-1:0]     level;
    logic [SeqWidth-1:0] seq_cnt;
    logic                overflow;
    logic [CntWidth-1:0] drop_cnt;

    logic                pop;
    logic [CalcW-1:0]    free;
    logic [CalcW-1:0]    n_valid;
    logic [CalcW-1:0]    n_acc;
    logic [CalcW-1:0]    n_drop;
    logic [NrPorts-1:0]  acc;
    logic [AddrW-1:0]    slot [NrPorts];
    logic [SeqWidth-1:0] tag  [NrPorts];
    logic [CntWidth:0]   drop_sum;

    // Valid ports are ranked in port order; the rank gives both the slot offset and the seq
    // offset, so dropped records still consume a tag and accepted ones leave no holes.
    always_comb begin
        pop      = (level != '0) && out_ready_i;
        free     = CalcW'(Depth) - CalcW'(level) + CalcW'(pop);
        n_valid  = '0;
        n_acc    = '0;
        for (int p = 0; p < NrPorts; p++) begin
            acc[p]  = 1'b0;
            slot[p] = wptr + n_valid[AddrW-1:0];
            tag[p]  = seq_cnt + SeqWidth'(n_valid);
            if (rec_valid_i[p]) begin
                if (n_valid < free) begin
                    acc[p] = 1'b1;
                    n_acc  = n_acc + 1'b1;
                end
                n_valid = n_valid + 1'b1;
            end
        end
        n_drop   = n_valid - n_acc;
        drop_sum = (clear_i ? '0 : {1'b0, drop_cnt}) + (CntWidth+1)'(n_drop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_rec[i]  <= '0;
                mem_port[i] <= '0;
                mem_seq[i]  <= '0;
            end
            rptr     <= '0;
            wptr     <= '0;
            level    <= '0;
            seq_cnt  <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            for (int p = 0; p < NrPorts; p++) begin
                if (acc[p]) begin
                    mem_rec[slot[p]]  <= rec_i[p];
                    mem_port[slot[p]] <= PortW'(p);
                    mem_seq[slot[p]]  <= tag[p];
                end
            end
            rptr    <= rptr + AddrW'(pop);
            wptr    <= wptr + n_acc[AddrW-1:0];
            level   <= level + n_acc[LvlW-1:0] - LvlW'(pop);
            seq_cnt <= seq_cnt + SeqWidth'(n_valid);
            // A drop in the same cycle as clear_i restarts the count from this cycle's drops.
            if (n_drop != '0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[CntWidth] ? '1 : drop_sum[CntWidth-1:0];
            end else if (clear_i) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    assign out_valid_o = (level != '0);
    assign out_rec_o   = mem_rec[rptr];
    assign out_port_o  = mem_port[rptr];
    assign out_seq_o   = mem_seq[rptr];
    assign level_o     = level;
    assign overflow_o  = overflow;
    assign drop_cnt_o  = drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rvfi_trace_serializer.sv
// tb_rvfi_trace_serializer: directed vector table plus hand-written overflow, saturation,
// clear and reset sequences for rvfi_trace_serializer (NrPorts=2, Depth=16).
`default_nettype none

module tb_rvfi_trace_serializer;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           rec_valid = '0;
    logic [1:0][255:0]    rec = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [255:0]         out_rec;
    logic [0:0]           out_port;
    logic [15:0]          out_seq;
    logic [4:0]           level;
    logic                 overflow;
    logic [15:0]          drop_cnt;
    logic                 clear = 1'b0;

    int total = 0;
    int bad   = 0;

    rvfi_trace_serializer #(
        .NrPorts (2),
        .RecWidth(256),
        .Depth   (16),
        .SeqWidth(16),
        .CntWidth(16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rec_valid_i(rec_valid),
        .rec_i      (rec),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_rec_o  (out_rec),
        .out_port_o (out_port),
        .out_seq_o  (out_seq),
        .level_o    (level),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt),
        .clear_i    (clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] v;
        logic       rdy;
        logic       clr;
        int         ra;
        int         rb;
        logic       ev;
        int         ep;
        int         es;
        int         erec;
        int         elvl;
        logic       eovf;
        int         edrop;
    } vec_t;

    function automatic logic [255:0] mk(input int n);
        return {8{32'(n)}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t tbl [14];

    initial begin
        for (int i = 0; i < 5; i++) tbl[i] = '{2'b00, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 1'b0, 0};
        tbl[5]  = '{2'b11, 1'b1, 1'b0, 1, 2, 1'b1, 0, 0, 1, 2, 1'b0, 0};
        tbl[6]  = '{2'b00, 1'b1, 1'b0, 0, 0, 1'b1, 1, 1, 2, 1, 1'b0, 0};
        tbl[7]  = '{2'b00, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 1'b0, 0};
        tbl[8]  = '{2'b10, 1'b1, 1'b0, 0, 3, 1'b1, 1, 2, 3, 1, 1'b0, 0};
        tbl[9]  = '{2'b01, 1'b1, 1'b0, 4, 0, 1'b1, 0, 3, 4, 1, 1'b0, 0};
        tbl[10] = '{2'b00, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 1'b0, 0};
        tbl[11] = '{2'b01, 1'b0, 1'b0, 5, 0, 1'b1, 0, 4, 5, 1, 1'b0, 0};
        tbl[12] = '{2'b00, 1'b0, 1'b0, 0, 0, 1'b1, 0, 4, 5, 1, 1'b0, 0};
        tbl[13] = '{2'b00, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 1'b0, 0};

        // reset state
        step();
        step();
        chk("reset_valid", 256'(out_valid), 256'(0));
        chk("reset_level", 256'(level), 256'(0));
        chk("reset_seq", 256'(out_seq), 256'(0));
        chk("reset_rec", out_rec, 256'(0));
        chk("reset_ovf", 256'(overflow), 256'(0));
        chk("reset_drop", 256'(drop_cnt), 256'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            rec_valid = tbl[i].v;
            out_ready = tbl[i].rdy;
            clear     = tbl[i].clr;
            rec[0]    = mk(tbl[i].ra);
            rec[1]    = mk(tbl[i].rb);
            step();
            chk($sformatf("vec%0d_valid", i), 256'(out_valid), 256'(tbl[i].ev));
            chk($sformatf("vec%0d_level", i), 256'(level), 256'(tbl[i].elvl));
            chk($sformatf("vec%0d_ovf", i), 256'(overflow), 256'(tbl[i].eovf));
            chk($sformatf("vec%0d_drop", i), 256'(drop_cnt), 256'(tbl[i].edrop));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_port", i), 256'(out_port), 256'(tbl[i].ep));
                chk($sformatf("vec%0d_seq", i), 256'(out_seq), 256'(tbl[i].es));
                chk($sformatf("vec%0d_rec", i), out_rec, mk(tbl[i].erec));
            end
        end
        rec_valid = '0;

        // fresh start: overflow with ready low
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_level", 256'(level), 256'(0));
        out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            rec_valid = 2'b11;
            rec[0]    = mk(100 + 2 * c);
            rec[1]    = mk(101 + 2 * c);
            step();
        end
        rec_valid = '0;
        chk("ovf_level", 256'(level), 256'(16));
        chk("ovf_flag", 256'(overflow), 256'(1));
        chk("ovf_drop", 256'(drop_cnt), 256'(2));

        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), 256'(out_valid), 256'(1));
            chk($sformatf("drain%0d_seq", i), 256'(out_seq), 256'(i));
            chk($sformatf("drain%0d_rec", i), out_rec, mk(100 + i));
            step();
        end
        chk("drain_empty", 256'(out_valid), 256'(0));

        out_ready = 1'b0;
        rec_valid = 2'b01;
        rec[0]    = mk(200);
        step();
        rec_valid = '0;
        chk("gap_seq", 256'(out_seq), 256'(18));
        chk("gap_port", 256'(out_port), 256'(0));
        chk("gap_rec", out_rec, mk(200));

        // fill to full: 15 more accepted, one dropped
        for (int c = 0; c < 8; c++) begin
            rec_valid = 2'b11;
            rec[0]    = mk(300 + 2 * c);
            rec[1]    = mk(301 + 2 * c);
            step();
        end
        chk("fill_level", 256'(level), 256'(16));
        chk("fill_drop", 256'(drop_cnt), 256'(3));

        // full with simultaneous pop: one accepted, one dropped
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        rec_valid = '0;
        chk("full_pop_level", 256'(level), 256'(16));
        chk("full_pop_drop", 256'(drop_cnt), 256'(4));
        chk("full_pop_head", 256'(out_seq), 256'(19));

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_ovf", 256'(overflow), 256'(0));
        chk("clear_drop", 256'(drop_cnt), 256'(0));
        chk("clear_level", 256'(level), 256'(16));

        // clear and drop in the same cycle: drop wins
        clear     = 1'b1;
        rec_valid = 2'b11;
        step();
        clear = 1'b0;
        chk("clrdrop_ovf", 256'(overflow), 256'(1));
        chk("clrdrop_drop", 256'(drop_cnt), 256'(2));

        for (int c = 0; c < 32766; c++) step();
        chk("sat_pre", 256'(drop_cnt), 256'(16'hFFFE));
        step();
        chk("sat_two", 256'(drop_cnt), 256'(16'hFFFF));
        rec_valid = 2'b01;
        step();
        chk("sat_hold", 256'(drop_cnt), 256'(16'hFFFF));
        chk("sat_ovf", 256'(overflow), 256'(1));
        rec_valid = '0;
        clear     = 1'b1;
        step();
        clear = 1'b0;
        chk("sat_clr_ovf", 256'(overflow), 256'(0));
        chk("sat_clr_drop", 256'(drop_cnt), 256'(0));

        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) step();
        out_ready = 1'b0;
        chk("pre_rst_level", 256'(level), 256'(7));

        // asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 256'(out_valid), 256'(0));
        chk("async_rst_level", 256'(level), 256'(0));
        step();
        rst_n     = 1'b1;
        rec_valid = 2'b01;
        rec[0]    = mk(7);
        step();
        rec_valid = '0;
        chk("post_rst_seq", 256'(out_seq), 256'(0));
        chk("post_rst_rec", out_rec, mk(7));
        chk("post_rst_level", 256'(level), 256'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
